// File: rtl/fpu_add_arbiter_if.sv
// Bundle between the requesters, the round-robin adder arbiter and the shared FP32 adder.
// master = requesters plus the adder result path; slave = the arbiter.
interface fpu_add_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREQ = 4
);
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [XLEN-1:0]      add_a;
  logic [XLEN-1:0]      add_b;
  logic [XLEN-1:0]      add_result;
  logic [NREQ-1:0]      rsp_valid;
  logic [XLEN-1:0]      rsp_data;
  logic                 busy;

  modport master (
    output en, req_valid, req_a, req_b, add_result,
    input  req_ready, add_a, add_b, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  en, req_valid, req_a, req_b, add_result,
    output req_ready, add_a, add_b, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fpu_add_arbiter.sv
// Round-robin sharing of one pipelined FP32 adder among NREQ requesters; an owner-tag
// pipeline matched to the adder latency routes each result back to its issuer.
module fpu_add_arbiter #(
  parameter int XLEN    = 32,
  parameter int NREQ    = 4,
  parameter int ADD_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  fpu_add_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  // Returns {found, index}: first valid requester searching upward from ptr, modulo NREQ.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] vld, input logic [PW-1:0] ptr);
    logic [PW:0]   sum_v;
    logic [PW-1:0] idx_v;
    logic [PW-1:0] win_v;
    logic          found_v;
    found_v = 1'b0;
    win_v   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_v = {1'b0, ptr} + (PW+1)'(k);
      sum_v = (sum_v >= NREQ_W) ? (sum_v - NREQ_W) : sum_v;
      idx_v = sum_v[PW-1:0];
      if (!found_v && vld[idx_v]) begin
        found_v = 1'b1;
        win_v   = idx_v;
      end else begin
        found_v = found_v;
      end
    end
    return {found_v, win_v};
  endfunction

  function automatic logic [PW-1:0] incr_mod(input logic [PW-1:0] idx);
    logic [PW:0] sum_v;
    sum_v = {1'b0, idx} + {{PW{1'b0}}, 1'b1};
    sum_v = (sum_v >= NREQ_W) ? (sum_v - NREQ_W) : sum_v;
    return sum_v[PW-1:0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] oh_v;
    oh_v      = '0;
    oh_v[idx] = 1'b1;
    return oh_v;
  endfunction

  logic [PW-1:0]   rr_ptr_r;
  logic [XLEN-1:0] add_a_r;
  logic [XLEN-1:0] add_b_r;
  logic [ADD_LAT:0] vld_r;
  logic [PW-1:0]   id_r [ADD_LAT+1];
  logic [NREQ-1:0] rsp_valid_r;
  logic [XLEN-1:0] rsp_data_r;

  logic [PW:0]     pick_s;
  logic [PW-1:0]   win_s;
  logic            acc_s;
  logic [NREQ-1:0] grant_s;
  logic [XLEN-1:0] opa_s [NREQ];
  logic [XLEN-1:0] opb_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opa_s[g] = bus.req_a[g*XLEN +: XLEN];
    assign opb_s[g] = bus.req_b[g*XLEN +: XLEN];
  end

  // Grant selection: round-robin winner, suppressed when en is low.
  always_comb begin
    grant_s = '0;
    acc_s   = 1'b0;
    pick_s  = rr_pick(bus.req_valid, rr_ptr_r);
    win_s   = pick_s[PW-1:0];
    if (bus.en && pick_s[PW]) begin
      grant_s = onehot(win_s);
      acc_s   = 1'b1;
    end else begin
      grant_s = '0;
      acc_s   = 1'b0;
    end
  end

  // Operand registers and priority pointer update on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
      add_a_r  <= '0;
      add_b_r  <= '0;
    end else if (acc_s) begin
      rr_ptr_r <= incr_mod(win_s);
      add_a_r  <= opa_s[win_s];
      add_b_r  <= opb_s[win_s];
    end else begin
      rr_ptr_r <= rr_ptr_r;
      add_a_r  <= add_a_r;
      add_b_r  <= add_b_r;
    end
  end

  // Owner tag pipeline; stage ADD_LAT lines up with the adder result for that op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int i = 0; i <= ADD_LAT; i++) begin
        id_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= acc_s;
      id_r[0]  <= win_s;
      for (int i = 1; i <= ADD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        id_r[i]  <= id_r[i-1];
      end
    end
  end

  // Response capture; data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= '0;
      rsp_data_r  <= '0;
    end else if (vld_r[ADD_LAT]) begin
      rsp_valid_r <= onehot(id_r[ADD_LAT]);
      rsp_data_r  <= bus.add_result;
    end else begin
      rsp_valid_r <= '0;
      rsp_data_r  <= rsp_data_r;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.add_a     = add_a_r;
  assign bus.add_b     = add_b_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = |vld_r;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter (NREQ=4, ADD_LAT=1) with a table-driven
// one-cycle adder model holding hand-computed IEEE-754 sums.
module tb_fpu_add_arbiter;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  fpu_add_arbiter_if #(.XLEN(32), .NREQ(4)) bus ();

  fpu_add_arbiter #(.XLEN(32), .NREQ(4), .ADD_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only operand pairs used below are known; anything else returns a marker value.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F800000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'h3F000000, 32'h3E800000}: return 32'h3F400000;
      {32'h3F800000, 32'h3F000000}: return 32'h3FC00000;
      {32'hBFC00000, 32'h3FC00000}: return 32'h00000000;
      default:                      return 32'h7FC0DEAD;
    endcase
  endfunction

  initial bus.add_result = 32'h0;
  always_ff @(posedge clk) bus.add_result <= fadd(bus.add_a, bus.add_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  logic [31:0] fa1 [4] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000};
  logic [31:0] fb1 [4] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h3E800000};
  logic [31:0] s1  [4] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'h3F400000};
  logic [31:0] fa3 [4] = '{32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F800000};
  logic [31:0] fb3 [4] = '{32'h3F000000, 32'h40000000, 32'h3E800000, 32'h3F800000};
  logic [31:0] s3  [4] = '{32'h3FC00000, 32'h40400000, 32'h3F400000, 32'h40000000};

  initial begin
    int w;
    int n1;
    int n3;
    int pc;
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset state
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_add_a", bus.add_a, 32'h0);
    chk("rst_add_b", bus.add_b, 32'h0);
    tick();
    chk("rst_hold_rsp", 32'(bus.rsp_valid), 32'h0);
    #2;
    rst_n = 1'b1;

    // All four requesters valid from reset: grants 0,1,2,3
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h3F000000, 32'h3E800000);
    set_req(3, 32'h3F800000, 32'h3F000000);
    bus.en = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("all4_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    chk("all4_add_a", bus.add_a, 32'h3F800000);
    chk("all4_busy", 32'(bus.busy), 32'h1);
    bus.req_valid = 4'b1110;
    #1;
    chk("all4_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    chk("all4_no_rsp_yet", 32'(bus.rsp_valid), 32'h0);
    bus.req_valid = 4'b1100;
    #1;
    chk("all4_ready2", 32'(bus.req_ready), 32'h4);
    tick();
    chk("all4_rsp0_v", 32'(bus.rsp_valid), 32'h1);
    chk("all4_rsp0_d", bus.rsp_data, 32'h40000000);
    bus.req_valid = 4'b1000;
    #1;
    chk("all4_ready3", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = 4'b0000;
    chk("all4_rsp1_v", 32'(bus.rsp_valid), 32'h2);
    chk("all4_rsp1_d", bus.rsp_data, 32'h40800000);
    tick();
    chk("all4_rsp2_v", 32'(bus.rsp_valid), 32'h4);
    chk("all4_rsp2_d", bus.rsp_data, 32'h3F400000);
    tick();
    chk("all4_rsp3_v", 32'(bus.rsp_valid), 32'h8);
    chk("all4_rsp3_d", bus.rsp_data, 32'h3FC00000);
    tick();
    chk("all4_rsp_end", 32'(bus.rsp_valid), 32'h0);
    chk("all4_busy_end", 32'(bus.busy), 32'h0);

    // Single op: 1.0 + 2.0 on requester 0
    set_req(0, 32'h3F800000, 32'h40000000);
    bus.req_valid = 4'b0001;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_busy_e0", 32'(bus.busy), 32'h1);
    chk("single_add_b", bus.add_b, 32'h40000000);
    tick();
    chk("single_rsp_early", 32'(bus.rsp_valid), 32'h0);
    chk("single_busy_e1", 32'(bus.busy), 32'h1);
    tick();
    chk("single_rsp_v", 32'(bus.rsp_valid), 32'h1);
    chk("single_rsp_d", bus.rsp_data, 32'h40400000);
    chk("single_busy_done", 32'(bus.busy), 32'h0);
    tick();
    chk("single_rsp_once", 32'(bus.rsp_valid), 32'h0);
    chk("single_data_hold", bus.rsp_data, 32'h40400000);

    // en gating; rr_ptr is now 1, single requester 0 still wins
    bus.en = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    chk("en_low_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("en_low_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("en_low_no_rsp", 32'(bus.rsp_valid), 32'h0);
    bus.en = 1'b1;
    #1;
    chk("en_high_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 32'h3F800000, 32'h3F800000);
    #1;
    chk("en_again_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.en = 1'b0;
    #1;
    chk("en_off_ready", 32'(bus.req_ready), 32'h0);
    chk("en_off_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("en_off_rsp1_v", 32'(bus.rsp_valid), 32'h1);
    chk("en_off_rsp1_d", bus.rsp_data, 32'h40400000);
    chk("en_off_busy1", 32'(bus.busy), 32'h1);
    tick();
    chk("en_off_rsp2_v", 32'(bus.rsp_valid), 32'h1);
    chk("en_off_rsp2_d", bus.rsp_data, 32'h40000000);
    chk("en_off_busy2", 32'(bus.busy), 32'h0);
    bus.req_valid = 4'b0000;
    bus.en = 1'b1;
    tick();
    chk("en_off_rsp_end", 32'(bus.rsp_valid), 32'h0);

    // Fairness: requesters 1 and 3 held valid, rr_ptr is 1
    n1 = 0;
    n3 = 0;
    set_req(1, fa1[0], fb1[0]);
    set_req(3, fa3[0], fb3[0]);
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      #1;
      w = (c % 2 == 0) ? 1 : 3;
      chk("fair_ready", 32'(bus.req_ready), 32'(1 << w));
      tick();
      if (w == 1) begin
        n1++;
        if (n1 < 4) set_req(1, fa1[n1], fb1[n1]);
      end else begin
        n3++;
        if (n3 < 4) set_req(3, fa3[n3], fb3[n3]);
      end
      if (c >= 2) begin
        pc = c - 2;
        chk("fair_rsp_v", 32'(bus.rsp_valid), (pc % 2 == 0) ? 32'h2 : 32'h8);
        chk("fair_rsp_d", bus.rsp_data, (pc % 2 == 0) ? s1[pc/2] : s3[pc/2]);
      end
    end
    bus.req_valid = 4'b0000;
    tick();
    chk("fair_rsp6_v", 32'(bus.rsp_valid), 32'h2);
    chk("fair_rsp6_d", bus.rsp_data, s1[3]);
    tick();
    chk("fair_rsp7_v", 32'(bus.rsp_valid), 32'h8);
    chk("fair_rsp7_d", bus.rsp_data, s3[3]);
    tick();
    chk("fair_end_busy", 32'(bus.busy), 32'h0);

    // Withdrawal of req 2 and -1.5 + 1.5 on req 1 (rr_ptr is 0)
    set_req(1, 32'hBFC00000, 32'h3FC00000);
    bus.req_valid = 4'b0110;
    #1;
    chk("wd_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("wd_ready_none", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    chk("wd_rsp_v", 32'(bus.rsp_valid), 32'h2);
    chk("wd_rsp_d", bus.rsp_data, 32'h00000000);
    tick();
    chk("wd_no_req2_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("wd_busy", 32'(bus.busy), 32'h0);

    // Reset with two ops in flight
    set_req(0, 32'h3F800000, 32'h40000000);
    bus.req_valid = 4'b0001;
    tick();
    tick();
    tick();
    bus.req_valid = 4'b0000;
    chk("mid_pre_rsp_d", bus.rsp_data, 32'h40400000);
    chk("mid_pre_busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_v", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_rsp_d", bus.rsp_data, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_add_a", bus.add_a, 32'h0);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("mid_after_rsp1", 32'(bus.rsp_valid), 32'h0);
    tick();
    chk("mid_after_rsp2", 32'(bus.rsp_valid), 32'h0);
    set_req(0, 32'h3F800000, 32'h3F800000);
    set_req(1, 32'h40000000, 32'h40000000);
    set_req(2, 32'h3F000000, 32'h3E800000);
    set_req(3, 32'h3F800000, 32'h3F000000);
    bus.req_valid = 4'b1111;
    #1;
    chk("mid_ptr_restart", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    tick();
    chk("mid_new_rsp_v", 32'(bus.rsp_valid), 32'h1);
    chk("mid_new_rsp_d", bus.rsp_data, 32'h40000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
